// File: rtl/ts_packet_framer_if.sv
// Signal bundle between a payload source / TS sink and the TS packet framer.
// Payload handshake: a byte moves on a clk edge where in_valid & in_ready are both 1;
// in_data/in_pusi must be stable while in_valid is high, and in_ready may depend on out_en.
interface ts_packet_framer_if;
    logic       out_en;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_pusi;
    logic       in_ready;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       pkt_start;
    logic       null_pkt;
    logic       underrun;
    logic [3:0] cc_out;
    logic [1:0] state_dbg;

    modport slave (
        input  out_en, in_data, in_valid, in_pusi,
        output in_ready, byte_out, byte_valid, pkt_start, null_pkt, underrun, cc_out, state_dbg
    );

    modport master (
        output out_en, in_data, in_valid, in_pusi,
        input  in_ready, byte_out, byte_valid, pkt_start, null_pkt, underrun, cc_out, state_dbg
    );
endinterface

// File: rtl/ts_packet_framer.sv
// MPEG-2 TS transmit framer: wraps a payload byte stream into 188-byte packets at the
// out_en byte rate, inserting null packets when no payload is waiting at a boundary.
module ts_packet_framer #(
    parameter logic [12:0] PID      = 13'h0100,
    parameter logic [12:0] NULL_PID = 13'h1FFF,
    parameter logic [7:0]  PAD_BYTE = 8'hFF
) (
    input logic              clk,
    input logic              rst,
    ts_packet_framer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HEADER  = 2'd1,
        PAYLOAD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [3:0]  cc_q, cc_d;
    logic        pusi_q, pusi_d;
    logic        null_q, null_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        start_q, start_d;
    logic        under_q, under_d;

    logic [7:0]  idx_next;
    logic [12:0] hdr_pid;
    logic [3:0]  hdr_cc;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cc_d     = cc_q;
        pusi_d   = pusi_q;
        null_d   = null_q;
        byte_d   = byte_q;
        valid_d  = bus.out_en;
        start_d  = 1'b0;
        under_d  = 1'b0;
        idx_next = (idx_q == 8'd187) ? 8'd0 : idx_q + 8'd1;
        hdr_pid  = null_q ? NULL_PID : PID;
        hdr_cc   = null_q ? 4'h0 : cc_q;

        if (bus.out_en) begin
            idx_d   = idx_next;
            state_d = (idx_next < 8'd4) ? HEADER : PAYLOAD;
            case (state_q)
                IDLE, HEADER: begin
                    case (idx_q[1:0])
                        2'd0: begin
                            // Packet type is fixed here; cc advances before use so it starts at 0.
                            start_d = 1'b1;
                            byte_d  = 8'h47;
                            null_d  = ~bus.in_valid;
                            pusi_d  = bus.in_valid & bus.in_pusi;
                            if (bus.in_valid) begin
                                cc_d = cc_q + 4'd1;
                            end
                        end
                        2'd1:    byte_d = {1'b0, pusi_q, 1'b0, hdr_pid[12:8]};
                        2'd2:    byte_d = hdr_pid[7:0];
                        default: byte_d = {4'b0001, hdr_cc};
                    endcase
                end
                PAYLOAD: begin
                    if (null_q || !bus.in_valid) begin
                        byte_d  = PAD_BYTE;
                        under_d = ~null_q;
                    end else begin
                        byte_d  = bus.in_data;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
            cc_q    <= 4'hF;
            pusi_q  <= 1'b0;
            null_q  <= 1'b0;
            byte_q  <= 8'h00;
            valid_q <= 1'b0;
            start_q <= 1'b0;
            under_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cc_q    <= cc_d;
            pusi_q  <= pusi_d;
            null_q  <= null_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            start_q <= start_d;
            under_q <= under_d;
        end
    end

    // A payload byte is taken only on a byte strobe inside a data packet's payload.
    assign bus.in_ready   = bus.out_en & (state_q == PAYLOAD) & ~null_q;
    assign bus.byte_out   = byte_q;
    assign bus.byte_valid = valid_q;
    assign bus.pkt_start  = start_q;
    assign bus.null_pkt   = null_q;
    assign bus.underrun   = under_q;
    assign bus.cc_out     = cc_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_ts_packet_framer.sv
// Directed bench for ts_packet_framer: each task drives one scenario and checks the
// emitted packets against hand-derived header/payload values.
module tb_ts_packet_framer;

    logic clk;
    logic rst;
    ts_packet_framer_if tif();

    ts_packet_framer dut (
        .clk (clk),
        .rst (rst),
        .bus (tif.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp;
    int n_fail;

    logic [7:0] src_byte;
    logic [7:0] last_bo;
    int         gap_bad;

    logic [7:0] o_bo;
    logic       o_bv, o_ps, o_nl, o_un, o_rdy;
    logic [3:0] o_cc;

    logic [7:0] pb  [188];
    logic       pst [188];
    logic       pnl [188];
    logic       pun [188];
    logic       pbv [188];
    logic       prd [188];
    logic [3:0] pcc [188];

    // One clock: drive at negedge, capture in_ready before the edge, outputs at next negedge.
    task automatic tick(input logic en, input logic vld, input logic pusi);
        tif.out_en   = en;
        tif.in_valid = vld;
        tif.in_pusi  = pusi;
        tif.in_data  = src_byte;
        #1;
        o_rdy = tif.in_ready;
        @(posedge clk);
        if (vld && o_rdy) src_byte = src_byte + 8'd1;
        @(negedge clk);
        o_bo = tif.byte_out;
        o_bv = tif.byte_valid;
        o_ps = tif.pkt_start;
        o_nl = tif.null_pkt;
        o_un = tif.underrun;
        o_cc = tif.cc_out;
    endtask

    task automatic do_reset();
        rst          = 1'b0;
        tif.out_en   = 1'b0;
        tif.in_valid = 1'b0;
        tif.in_pusi  = 1'b0;
        tif.in_data  = 8'h00;
        src_byte     = 8'h00;
        last_bo      = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    // Emit n bytes with `gap` idle cycles before each; in_valid drops over [drop_lo, drop_hi].
    task automatic get_packet(input int n, input int gap, input logic vld, input logic pusi,
                              input int drop_lo, input int drop_hi);
        gap_bad = 0;
        for (int i = 0; i < n; i++) begin
            logic v;
            v = vld && !(i >= drop_lo && i <= drop_hi);
            for (int g = 0; g < gap; g++) begin
                tick(1'b0, v, pusi);
                if (o_bv !== 1'b0 || o_rdy !== 1'b0 || o_ps !== 1'b0 || o_un !== 1'b0 || o_bo !== last_bo)
                    gap_bad++;
            end
            tick(1'b1, v, pusi);
            pb[i]  = o_bo;
            pst[i] = o_ps;
            pnl[i] = o_nl;
            pun[i] = o_un;
            pbv[i] = o_bv;
            prd[i] = o_rdy;
            pcc[i] = o_cc;
            last_bo = o_bo;
        end
    endtask

    task automatic test_reset();
        rst          = 1'b0;
        tif.out_en   = 1'b1;
        tif.in_valid = 1'b1;
        tif.in_pusi  = 1'b1;
        tif.in_data  = 8'hA5;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (tif.byte_out !== 8'h00 || tif.byte_valid !== 1'b0 || tif.pkt_start !== 1'b0 ||
            tif.null_pkt !== 1'b0 || tif.underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got bo=%h bv=%b ps=%b nl=%b un=%b, expected all 0",
                     tif.byte_out, tif.byte_valid, tif.pkt_start, tif.null_pkt, tif.underrun);
        end
        n_cmp++;
        if (tif.cc_out !== 4'hF || tif.in_ready !== 1'b0 || tif.state_dbg !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_cc_state: got cc=%h rdy=%b st=%0d, expected cc=f rdy=0 st=0",
                     tif.cc_out, tif.in_ready, tif.state_dbg);
        end
        do_reset();
        src_byte = 8'h00;
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        n_cmp++;
        if (o_bv !== 1'b0 || o_rdy !== 1'b0 || o_bo !== 8'h00 || o_cc !== 4'hF) begin
            n_fail++;
            $display("FAIL idle_no_strobe: got bv=%b rdy=%b bo=%h cc=%h, expected 0 0 00 f",
                     o_bv, o_rdy, o_bo, o_cc);
        end
    endtask

    task automatic test_continuous();
        do_reset();
        for (int k = 0; k < 17; k++) begin
            logic       p;
            logic [7:0] e1, e3, eb;
            int         bad, fbad;
            p   = ~k[0];
            e1  = {1'b0, p, 1'b0, 5'h01};
            e3  = {4'h1, k[3:0]};
            get_packet(188, 0, 1'b1, p, -1, -1);
            n_cmp++;
            if (pb[0] !== 8'h47 || pb[1] !== e1 || pb[2] !== 8'h00 || pb[3] !== e3) begin
                n_fail++;
                $display("FAIL cont_header pkt %0d: got %h %h %h %h, expected 47 %h 00 %h",
                         k, pb[0], pb[1], pb[2], pb[3], e1, e3);
            end
            bad  = -1;
            fbad = -1;
            for (int i = 0; i < 188; i++) begin
                eb = 8'((k * 184 + i - 4) & 255);
                if (i >= 4 && pb[i] !== eb && bad < 0) bad = i;
                if ((pst[i] !== (i == 0) || pbv[i] !== 1'b1 || pnl[i] !== 1'b0 ||
                     pun[i] !== 1'b0 || prd[i] !== (i >= 4)) && fbad < 0) fbad = i;
            end
            n_cmp++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL cont_payload pkt %0d idx %0d: got %h, expected %h",
                         k, bad, pb[bad], 8'((k * 184 + bad - 4) & 255));
            end
            n_cmp++;
            if (fbad >= 0) begin
                n_fail++;
                $display("FAIL cont_flags pkt %0d idx %0d: got ps=%b bv=%b nl=%b un=%b rdy=%b, expected ps=%b 1 0 0 rdy=%b",
                         k, fbad, pst[fbad], pbv[fbad], pnl[fbad], pun[fbad], prd[fbad], fbad == 0, fbad >= 4);
            end
            n_cmp++;
            if (pcc[0] !== k[3:0]) begin
                n_fail++;
                $display("FAIL cont_cc pkt %0d: got %h, expected %h", k, pcc[0], k[3:0]);
            end
        end
    endtask

    task automatic test_null();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            int bad;
            get_packet(188, 0, 1'b0, 1'b1, -1, -1);
            n_cmp++;
            if (pb[0] !== 8'h47 || pb[1] !== 8'h1F || pb[2] !== 8'hFF || pb[3] !== 8'h10) begin
                n_fail++;
                $display("FAIL null_header pkt %0d: got %h %h %h %h, expected 47 1f ff 10",
                         k, pb[0], pb[1], pb[2], pb[3]);
            end
            bad = -1;
            for (int i = 0; i < 188; i++) begin
                if (((i >= 4 && pb[i] !== 8'hFF) || pnl[i] !== 1'b1 || prd[i] !== 1'b0 ||
                     pun[i] !== 1'b0 || pcc[i] !== 4'hF) && bad < 0) bad = i;
            end
            n_cmp++;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL null_body pkt %0d idx %0d: got bo=%h nl=%b rdy=%b un=%b cc=%h, expected ff 1 0 0 f",
                         k, bad, pb[bad], pnl[bad], prd[bad], pun[bad], pcc[bad]);
            end
        end
    endtask

    task automatic test_underrun();
        int bad;
        do_reset();
        get_packet(188, 0, 1'b1, 1'b0, 50, 52);
        n_cmp++;
        if (pb[49] !== 8'h2D || pb[50] !== 8'hFF || pb[51] !== 8'hFF || pb[52] !== 8'hFF ||
            pb[53] !== 8'h2E || pb[187] !== 8'hB4) begin
            n_fail++;
            $display("FAIL underrun_bytes: got %h %h %h %h %h last=%h, expected 2d ff ff ff 2e last=b4",
                     pb[49], pb[50], pb[51], pb[52], pb[53], pb[187]);
        end
        bad = -1;
        for (int i = 0; i < 188; i++)
            if (pun[i] !== (i >= 50 && i <= 52) && bad < 0) bad = i;
        n_cmp++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL underrun_pulses idx %0d: got %b, expected %b", bad, pun[bad], bad >= 50 && bad <= 52);
        end
        get_packet(5, 0, 1'b1, 1'b0, -1, -1);
        n_cmp++;
        if (pst[0] !== 1'b1 || pb[0] !== 8'h47 || pb[3] !== 8'h11 || pb[4] !== 8'hB5) begin
            n_fail++;
            $display("FAIL underrun_next_pkt: got ps=%b %h cc_byte=%h first=%h, expected 1 47 11 b5",
                     pst[0], pb[0], pb[3], pb[4]);
        end
    endtask

    task automatic test_sparse();
        int bad;
        do_reset();
        get_packet(188, 3, 1'b1, 1'b1, -1, -1);
        n_cmp++;
        if (pb[0] !== 8'h47 || pb[1] !== 8'h41 || pb[2] !== 8'h00 || pb[3] !== 8'h10) begin
            n_fail++;
            $display("FAIL sparse_header: got %h %h %h %h, expected 47 41 00 10", pb[0], pb[1], pb[2], pb[3]);
        end
        bad = -1;
        for (int i = 4; i < 188; i++)
            if ((pb[i] !== 8'(i - 4) || pbv[i] !== 1'b1 || prd[i] !== 1'b1) && bad < 0) bad = i;
        n_cmp++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL sparse_payload idx %0d: got bo=%h bv=%b rdy=%b, expected %h 1 1",
                     bad, pb[bad], pbv[bad], prd[bad], 8'(bad - 4));
        end
        n_cmp++;
        if (gap_bad !== 0) begin
            n_fail++;
            $display("FAIL sparse_gaps: got %0d bad idle cycles, expected 0", gap_bad);
        end
        n_cmp++;
        if (src_byte !== 8'hB8) begin
            n_fail++;
            $display("FAIL sparse_consumed: got %h bytes taken, expected b8", src_byte);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int k = 0; k < 5; k++) get_packet(188, 0, 1'b1, 1'b0, -1, -1);
        get_packet(100, 0, 1'b1, 1'b0, -1, -1);
        n_cmp++;
        if (pb[3] !== 8'h15 || pcc[99] !== 4'h5) begin
            n_fail++;
            $display("FAIL midrst_pre_cc: got cc_byte=%h cc=%h, expected 15 5", pb[3], pcc[99]);
        end
        tif.out_en   = 1'b1;
        tif.in_valid = 1'b1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if (tif.byte_out !== 8'h00 || tif.byte_valid !== 1'b0 || tif.cc_out !== 4'hF || tif.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_async_clear: got bo=%h bv=%b cc=%h rdy=%b, expected 00 0 f 0",
                     tif.byte_out, tif.byte_valid, tif.cc_out, tif.in_ready);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (tif.byte_out !== 8'h00 || tif.byte_valid !== 1'b0 || tif.pkt_start !== 1'b0 || tif.underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_held: got bo=%h bv=%b ps=%b un=%b, expected 00 0 0 0",
                     tif.byte_out, tif.byte_valid, tif.pkt_start, tif.underrun);
        end
        rst = 1'b1;
        get_packet(4, 0, 1'b1, 1'b0, -1, -1);
        n_cmp++;
        if (pb[0] !== 8'h47 || pst[0] !== 1'b1 || pb[3] !== 8'h10 || pcc[0] !== 4'h0) begin
            n_fail++;
            $display("FAIL midrst_restart: got %h ps=%b cc_byte=%h cc=%h, expected 47 1 10 0",
                     pb[0], pst[0], pb[3], pcc[0]);
        end
    endtask

    task automatic test_alternate();
        do_reset();
        get_packet(188, 0, 1'b1, 1'b0, -1, -1);
        n_cmp++;
        if (pnl[0] !== 1'b0 || pb[3] !== 8'h10 || pcc[0] !== 4'h0) begin
            n_fail++;
            $display("FAIL alt_data0: got nl=%b cc_byte=%h cc=%h, expected 0 10 0", pnl[0], pb[3], pcc[0]);
        end
        get_packet(188, 0, 1'b0, 1'b0, -1, -1);
        n_cmp++;
        if (pnl[0] !== 1'b1 || pb[1] !== 8'h1F || pb[3] !== 8'h10 || pcc[187] !== 4'h0) begin
            n_fail++;
            $display("FAIL alt_null: got nl=%b pid_hi=%h cc_byte=%h cc=%h, expected 1 1f 10 0",
                     pnl[0], pb[1], pb[3], pcc[187]);
        end
        get_packet(188, 0, 1'b1, 1'b0, -1, -1);
        n_cmp++;
        if (pnl[0] !== 1'b0 || pb[3] !== 8'h11 || pcc[0] !== 4'h1 || pb[4] !== 8'hB8) begin
            n_fail++;
            $display("FAIL alt_data1: got nl=%b cc_byte=%h cc=%h first=%h, expected 0 11 1 b8",
                     pnl[0], pb[3], pcc[0], pb[4]);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_cmp        = 0;
        n_fail       = 0;
        rst          = 1'b0;
        src_byte     = 8'h00;
        last_bo      = 8'h00;
        tif.out_en   = 1'b0;
        tif.in_valid = 1'b0;
        tif.in_pusi  = 1'b0;
        tif.in_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_continuous();
        test_null();
        test_underrun();
        test_sparse();
        test_reset_mid();
        test_alternate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/ts_packet_framer.md
# ts_packet_framer

Transmit-side MPEG-2 TS packet framer. It takes a raw payload byte stream through a valid/ready handshake and emits a constant-rate stream of 188-byte TS packets, one byte per output strobe. Each packet carries sync byte 0x47, a 4-byte header with a configured PID and a 4-bit continuity counter, and 184 payload bytes. When no payload is pending at a packet boundary, it inserts a null packet to hold the output rate. It is the source end for the downstream sync recovery and QoS path.

## Interface
- PID, 13'h0100, PID placed in header bytes 1–2 of data packets
- NULL_PID, 13'h1FFF, PID of inserted null packets
- PAD_BYTE, 8'hFF, filler for null payload and for underrun bytes
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- out_en  in  1  byte-rate strobe; one output byte is produced per cycle with out_en=1
- in_data  in  8  payload byte
- in_valid  in  1  in_data valid
- in_pusi  in  1  payload_unit_start flag, sampled at packet start
- in_ready  out  1  payload byte accepted this cycle when in_valid & in_ready
- byte_out  out  8  TS byte
- byte_valid  out  1  byte_out valid (registered copy of out_en)
- pkt_start  out  1  high with the 0x47 byte of every packet
- null_pkt  out  1  high for all 188 bytes of a null packet
- underrun  out  1  one-cycle pulse per padded payload byte in a data packet
- cc_out  out  4  continuity counter of the current or most recent data packet

## Operation
- Byte index idx counts 0..187 and advances only on out_en. At 187, it wraps to 0 on the next out_en.
- States:
  - IDLE: after reset; stays here until the first out_en, which emits idx 0.
  - HEADER: idx 0..3.
  - PAYLOAD: idx 4..187.
  - From PAYLOAD at idx 187, the next out_en returns to HEADER. There is no return to IDLE except by reset.
- Packet type is decided at the idx 0 out_en:
  - in_valid=1 gives a data packet. in_pusi is latched. cc increments modulo 16 *before* use: the first data packet after reset carries cc=0, so the cc register resets to 4'hF.
  - in_valid=0 gives a null packet. cc is unchanged.
- Header bytes:
  - idx0 = 8'h47.
  - idx1 = {1'b0, pusi, 1'b0, pid[12:8]}.
  - idx2 = pid[7:0].
  - idx3 = {2'b00, 2'b01, cc}.
  - For null packets: pid = NULL_PID, pusi = 0, cc field = 0.
- Payload, data packet:
  - in_ready = out_en & (state==PAYLOAD) & !null. This is combinational, and in_ready is 0 in every other state.
  - If in_valid=1, byte_out = in_data.
  - If in_valid=0, byte_out = PAD_BYTE and underrun pulses. The packet still completes, so there is no resync.
- Payload, null packet: byte_out = PAD_BYTE, and no input is consumed.
- in_valid is never consumed during HEADER. Data presented there waits.

## Timing
- Reset values:
  - byte_out = 0; byte_valid, pkt_start, null_pkt and underrun = 0.
  - cc = 4'hF, so cc_out reads 4'hF until the first data packet.
  - idx = 0; state = IDLE.
- Latency: byte_out, byte_valid, pkt_start, null_pkt and underrun are registered. They appear the cycle after the out_en that produced them.
- out_en=0 cycles:
  - byte_valid=0 and pkt_start=0.
  - byte_out holds its last value.
  - State, idx and cc are unchanged.
- Gaps in out_en of any length are legal, including mid-header.
- Back-to-back out_en gives 188 consecutive byte_valid cycles per packet, with no idle byte between packets.
- cc_out updates in the cycle byte_valid shows idx 0 of a data packet.
- Reset mid-packet:
  - All outputs are cleared asynchronously.
  - The partial packet is abandoned.
  - The next output is a fresh idx 0 with cc restarting at 0.
- Simultaneous in_valid rise and idx 0 out_en makes a data packet. A rise one cycle later makes a null packet; that data waits for the next boundary.

## Test plan
- Continuous out_en, in_valid=1, in_data incrementing from 0x00:
  - Packets show 47 01 00 1x, with pusi per in_pusi.
  - Payload is 0x00..0xB7, then 0xB8...
  - cc = 0,1,2…; after 16 packets cc wraps 0xF→0x0.
- in_valid=0 throughout:
  - Every packet is 47 1F FF 10 followed by 184×FF.
  - null_pkt=1 for all 188 bytes; in_ready never 1; cc_out stays 0xF.
- Data packet with in_valid dropped for 3 cycles at idx 50:
  - Three FF bytes at idx 50..52, with three underrun pulses.
  - Byte idx 53 resumes with the next in_data.
  - The packet is exactly 188 bytes; the next sync byte is on schedule.
- out_en asserted 1-in-4 cycles:
  - byte_valid is 1-in-4.
  - Byte sequence identical to the continuous case.
  - in_ready only coincides with out_en.
- Reset asserted at idx 100 of cc=5 packet:
  - Outputs are 0 during reset.
  - After release, the first byte is 0x47 with cc=0.
- Alternating in_valid at boundaries: data, null, data, with cc 0, (null), 1. The null packet does not advance cc.
